// File: rtl/bram_fifo_ctrl.sv
// Valid/ready FIFO controller for a dual-port BRAM. Port A writes and port B reads.
// A 2-entry output buffer absorbs the 1-cycle BRAM read latency so the output streams at full rate.
module bram_fifo_ctrl #(
  parameter int DEPTH  = 4096,
  parameter int BITS_D = 18,
  localparam int BITS_A = $clog2(DEPTH),
  localparam int BITS_C = $clog2(DEPTH + 3)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [BITS_D-1:0] i_data,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [BITS_D-1:0] o_data,
  output logic [BITS_C-1:0] count,
  output logic              wena,
  output logic [BITS_A-1:0] addra,
  output logic [BITS_D-1:0] wdataa,
  output logic [BITS_A-1:0] addrb,
  input  logic [BITS_D-1:0] rdatab
);

  logic [BITS_A-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [BITS_C-1:0] bram_cnt_q, bram_cnt_d;
  logic [BITS_C-1:0] count_q, count_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        ob_cnt_q, ob_cnt_d;
  logic [BITS_D-1:0] ob0_q, ob0_d, ob1_q, ob1_d;
  logic              i_ready_q, i_ready_d;
  logic              push, pop, issue;
  logic [2:0]        occ;
  logic [2:0]        ob_next;
  logic [1:0]        slot;

  always_comb begin
    push       = i_valid && i_ready_q;
    pop        = (ob_cnt_q != 2'd0) && o_ready;
    // buffer slots already committed after this cycle's pop
    occ        = 3'(ob_cnt_q) + 3'(inflight_q) - 3'(pop);
    issue      = (bram_cnt_q != '0) && (occ < 3'd2);

    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    if (push) wptr_d = (wptr_q == BITS_A'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
    if (issue) rptr_d = (rptr_q == BITS_A'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;

    bram_cnt_d = bram_cnt_q;
    if (push && !issue) bram_cnt_d = bram_cnt_q + 1'b1;
    else if (!push && issue) bram_cnt_d = bram_cnt_q - 1'b1;

    inflight_d = issue;
    ob_next    = 3'(ob_cnt_q) - 3'(pop) + 3'(inflight_q);
    ob_cnt_d   = ob_next[1:0];

    slot       = ob_cnt_q - 2'(pop);
    ob0_d      = ob0_q;
    ob1_d      = ob1_q;
    if (pop) ob0_d = ob1_q;
    if (inflight_q) begin
      if (slot == 2'd0) ob0_d = rdatab;
      else              ob1_d = rdatab;
    end

    count_d    = bram_cnt_d + BITS_C'(inflight_d) + BITS_C'(ob_cnt_d);
    i_ready_d  = (bram_cnt_d < BITS_C'(DEPTH));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      bram_cnt_q <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      ob_cnt_q   <= 2'd0;
      ob0_q      <= '0;
      ob1_q      <= '0;
      i_ready_q  <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      bram_cnt_q <= bram_cnt_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      ob_cnt_q   <= ob_cnt_d;
      ob0_q      <= ob0_d;
      ob1_q      <= ob1_d;
      i_ready_q  <= i_ready_d;
    end
  end

  assign i_ready = i_ready_q;
  assign o_valid = (ob_cnt_q != 2'd0);
  assign o_data  = ob0_q;
  assign count   = count_q;
  assign wena    = push;
  assign addra   = wptr_q;
  assign wdataa  = i_data;
  assign addrb   = rptr_q;

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Bench for bram_fifo_ctrl: behavioural BRAM, scoreboard queue of accepted words, directed and random phases.
module tb_bram_fifo_ctrl;
  localparam int DEPTH  = 12;
  localparam int BITS_D = 18;
  localparam int BITS_A = $clog2(DEPTH);
  localparam int BITS_C = $clog2(DEPTH + 3);

  logic              clk = 1'b0;
  logic              rstn;
  logic              i_valid, i_ready, o_valid, o_ready, wena;
  logic [BITS_D-1:0] i_data, o_data, wdataa, rdatab;
  logic [BITS_C-1:0] count;
  logic [BITS_A-1:0] addra, addrb;

  int total = 0;
  int bad   = 0;
  int nxt   = 1;
  logic [BITS_D-1:0] sb[$];
  logic [BITS_D-1:0] mem [0:DEPTH-1];
  logic              prev_stall = 1'b0;
  logic [BITS_D-1:0] prev_data  = '0;

  bram_fifo_ctrl #(.DEPTH(DEPTH), .BITS_D(BITS_D)) dut (
    .clk(clk), .rstn(rstn), .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .count(count),
    .wena(wena), .addra(addra), .wdataa(wdataa), .addrb(addrb), .rdatab(rdatab)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wena) mem[addra] <= wdataa;
    rdatab <= mem[addrb];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [BITS_D-1:0] word(input int n);
    word = BITS_D'(n * 37) ^ 18'h2A5A5;
  endfunction

  // Sampled on the falling edge: checks state after the last rising edge,
  // then records the handshakes that the next rising edge will commit.
  always @(negedge clk) begin
    if (!rstn) begin
      sb.delete();
      prev_stall = 1'b0;
      chk("rst_cnt", 32'(count), 0);
    end else begin
      chk("count", 32'(count), 32'(sb.size()));
      chk("addra_rng", 32'(addra < BITS_A'(DEPTH)), 1);
      chk("addrb_rng", 32'(addrb < BITS_A'(DEPTH)), 1);
      if (prev_stall) chk("hold", 32'(o_data), 32'(prev_data));
      if (i_valid && i_ready) begin
        sb.push_back(i_data);
        nxt++;
      end
      if (o_valid && o_ready) begin
        if (sb.size() == 0) chk("underflow", 32'(o_data), 32'hFFFF_FFFF);
        else chk("data", 32'(o_data), 32'(sb.pop_front()));
      end
      prev_stall = o_valid && !o_ready;
      prev_data  = o_data;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    rstn = 1'b0; i_valid = 1'b1; i_data = 18'h155; o_ready = 1'b0;
    repeat (3) cyc();
    chk("rst_iready", 32'(i_ready), 0);
    chk("rst_ovalid", 32'(o_valid), 0);
    chk("rst_wena", 32'(wena), 0);
    rstn = 1'b1;
    cyc();
    chk("iready_rise", 32'(i_ready), 1);
    cyc();                                  // E0: 0x155 pushed
    i_valid = 1'b0;
    chk("e0_count", 32'(count), 1);
    chk("e0_ovalid", 32'(o_valid), 0);
    cyc();
    chk("e1_ovalid", 32'(o_valid), 0);
    cyc();
    chk("e2_ovalid", 32'(o_valid), 1);
    chk("e2_odata", 32'(o_data), 32'h155);
    o_ready = 1'b1;
    cyc();
    o_ready = 1'b0;
    repeat (2) cyc();

    // fill with output stalled
    base = nxt;
    i_valid = 1'b1;
    repeat (30) begin
      i_data = word(nxt);
      cyc();
    end
    i_valid = 1'b0;
    chk("full_iready", 32'(i_ready), 0);
    chk("full_count", 32'(count), DEPTH + 2);
    chk("full_head", 32'(o_data), 32'(word(base)));
    o_ready = 1'b1;
    cyc();
    o_ready = 1'b0;
    chk("pulse_head", 32'(o_data), 32'(word(base + 1)));
    repeat (2) cyc();
    chk("iready_back", 32'(i_ready), 1);

    // refill then stream at full with push and pop together
    i_valid = 1'b1;
    repeat (6) begin
      i_data = word(nxt);
      cyc();
    end
    chk("refull_count", 32'(count), DEPTH + 2);
    o_ready = 1'b1;
    repeat (50) begin
      i_data = word(nxt);
      cyc();
      chk("full_band", 32'(count >= BITS_C'(DEPTH + 1) && count <= BITS_C'(DEPTH + 2)), 1);
    end

    // random handshakes
    repeat (600) begin
      i_valid = 1'($urandom_range(0, 1));
      o_ready = ($urandom_range(0, 3) != 0);
      i_data  = word(nxt);
      cyc();
    end
    i_valid = 1'b0; o_ready = 1'b1;
    for (int k = 0; k < 60 && sb.size() != 0; k++) cyc();
    chk("drain1", 32'(sb.size()), 0);

    // reset with words stored
    o_ready = 1'b0; i_valid = 1'b1;
    repeat (8) begin
      i_data = word(nxt);
      cyc();
    end
    i_valid = 1'b0;
    cyc();
    rstn = 1'b0;
    #1;
    chk("midrst_ovalid", 32'(o_valid), 0);
    chk("midrst_count", 32'(count), 0);
    cyc();
    rstn = 1'b1;
    i_valid = 1'b1; o_ready = 1'b1;
    repeat (10) begin
      i_data = word(nxt);
      cyc();
    end
    i_valid = 1'b0;
    for (int k = 0; k < 60 && sb.size() != 0; k++) cyc();
    chk("drain2", 32'(sb.size()), 0);
    repeat (2) cyc();
    chk("end_ovalid", 32'(o_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_fifo_ctrl.md
# bram_fifo_ctrl

Synchronous FIFO controller that turns the dual-port flexible BRAM wrapper into a valid/ready stream buffer. Port A of the BRAM is the write port and port B is the read port. The controller owns both pointers, the occupancy accounting and a 2-entry output buffer that hides the BRAM's 1-cycle read latency, so the output sustains one word per cycle. It sits directly upstream of the BRAM instance, and both share one clock: clka and clkb of the BRAM are tied to `clk`.

## Interface
Parameters:
- `DEPTH`, default 4096: BRAM word count. Must match the BRAM instance. Any value ≥2 is legal; a power of two is not required.
- `BITS_D`, default 18: data width. Must match the BRAM instance.
- `BITS_A`, derived: ceil(log2(DEPTH)). BRAM address width.
- `BITS_C`, derived: ceil(log2(DEPTH+3)). Occupancy width.

Ports:
- `clk`, in, 1: the single clock. Reset is asynchronous and active-low.
- `rstn`, in, 1: asynchronous, active-low reset.
- `i_valid`, in, 1: input word valid.
- `i_ready`, out, 1: registered; high when the BRAM has a free slot.
- `i_data`, in, BITS_D: input word.
- `o_valid`, out, 1: registered; high when `o_data` holds the head word.
- `o_ready`, in, 1: consumer accepts the head word.
- `o_data`, out, BITS_D: registered head word.
- `count`, out, BITS_C: registered total occupancy (BRAM + in-flight + output buffer).
- `wena`, out, 1: to BRAM port A write enable. Equals `i_valid && i_ready`.
- `addra`, out, BITS_A: to BRAM port A. Equals `wptr`.
- `wdataa`, out, BITS_D: to BRAM port A. Equals `i_data`.
- `addrb`, out, BITS_A: to BRAM port B. Equals `rptr`.
- `rdatab`, in, BITS_D: from BRAM port B. Data for the address presented on the previous cycle.

## Operation
- State:
  - `wptr`, `rptr` (BITS_A bits)
  - `bram_cnt` (0..DEPTH)
  - `inflight` (1 bit)
  - output buffer `ob0`/`ob1` with `ob_cnt` (0..2)
- Push: `push = i_valid && i_ready`. On push, `wptr` advances and `bram_cnt` increments.
- Pointer wrap: each pointer goes from DEPTH-1 to 0. This is an explicit compare, not modulo 2^BITS_A.
- Pop: `pop = o_valid && o_ready`. On pop, `ob1` shifts into `ob0` and `ob_cnt` decrements.
- Read issue: `issue = (bram_cnt > 0) && (ob_cnt + inflight - pop < 2)`.
  - On issue, `rptr` advances, `bram_cnt` decrements and `inflight` is set for the next cycle.
- Capture: when `inflight` is set, `rdatab` is written into the first free buffer slot after accounting for the pop in the same cycle. `rdatab` is ignored whenever `inflight` is 0.
- Simultaneous events:
  - Push and issue in the same cycle: `bram_cnt` is unchanged.
  - Pop and capture in the same cycle: `ob_cnt` is unchanged.
- Read/write collision: a same-cycle read and write to the same address cannot occur.
  - `bram_cnt` counts only words already written on a previous edge.
  - Writes are blocked when `bram_cnt == DEPTH`.
  - The BRAM's READ_FIRST setting is therefore irrelevant.
- Flag and count updates:
  - `i_ready_next = (bram_cnt_next < DEPTH)`.
  - `o_valid = (ob_cnt > 0)`.
  - `count_next = bram_cnt_next + inflight_next + ob_cnt_next`. Maximum value is DEPTH+2.
- Output data: `o_data` is always `ob0`. Its value is don't-care while `o_valid` is 0, but it must not change while `o_valid && !o_ready`.

## Timing
- Reset (async, while `rstn` = 0):
  - `i_ready` = 0, `o_valid` = 0, `count` = 0, `o_data` = 0
  - pointers = 0, `inflight` = 0, `ob_cnt` = 0
  - `wena` = 0, because `i_ready` = 0.
- `i_ready` rises on the first clk edge after `rstn` is released.
- Reset mid-operation drops all contents. BRAM contents are not cleared but are logically discarded.
- First-word latency into an empty FIFO:
  - Push on edge E0.
  - Issue in the cycle after E0; `addrb` = word address.
  - Capture on edge E2; `o_valid` is high after E2.
- Throughput: with `bram_cnt` > 0 and `o_ready` held high, `o_valid` stays high and one word is popped per cycle, with no bubbles.
- Backpressure: with `o_ready` = 0, at most 2 words are prefetched into the output buffer. Further words remain in the BRAM.
- Full: `i_ready` drops on the edge where `bram_cnt` reaches DEPTH, so no write is accepted in the following cycle. It rises on the edge after the first issue that frees a slot.
- Empty: `o_valid` drops on the edge of the last pop when `ob_cnt` becomes 0 and no capture is pending.

## Test plan
- Reset and first word: hold `rstn` = 0 with `i_valid` = 1. Check `i_ready` = 0, `o_valid` = 0, `count` = 0. Release `rstn`, push 0x155 on E0. Required: `o_valid` = 1 with `o_data` = 0x155 after E2, and `count` = 1 after E0.
- Streaming: with DEPTH=4096, push 0..9999 with `o_ready` = 1. Required: output sequence in order and gap-free. Pointers must wrap past 4095 with no loss.
- Fill/backpressure: DEPTH=16, `o_ready` = 0, push continuously. Required: `i_ready` = 0 once 18 words are accepted, with `count` = 18 and `o_data` = word 0. Then pulse `o_ready` for one cycle: `o_data` = word 1 next, and `i_ready` returns within 2 cycles.
- Non-power-of-2 depth: DEPTH=1000. Push and pop 3000 words with random `i_valid`/`o_ready`. Required: `addra`/`addrb` never exceed 999, and data order is preserved.
- Simultaneous push/pop at full: DEPTH=16, full. Assert `o_ready` = 1 and `i_valid` = 1 for 50 cycles. Required: `count` stays in 17..18, with no duplicated or lost words.
- Reset mid-stream: 8 words stored, assert `rstn` = 0 for one cycle. Required: `o_valid` = 0 immediately. Words pushed after reset come out first and in order, with no stale data.
